bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the single external memory bus (adress_bus, date_bus, r, w) between two requesters.
- Port 0 is the CPU core. Port 1 is a DMA/video fetch engine.
- Sequences each granted access through fixed address-setup, wait and completion phases.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the CPU/peripherals and the memory decoder.

Parameters:
- WAIT_CYCLES, 1, extra cycles r/w is held after the first access cycle (0..15).
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a tie.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  port 0 access request, held until ack0
- lock0  input  1  port 0 keeps the bus for a back-to-back access
- addr0  input  16  port 0 address
- we0  input  1  port 0 write (1) / read (0)
- wdata0  input  8  port 0 write data
- ack0  output  1  port 0 access complete, one-cycle pulse
- req1, lock1, addr1, we1, wdata1, ack1  as port 0, for port 1
- rdata  output  8  read data, valid when ack0 or ack1 is high
- grant  output  1  index of the current/last bus owner
- busy  output  1  high in ACCESS and DONE
- adress_bus  output  16  external address
- date_bus_out  output  8  external write data
- date_bus_oe  output  1  drive enable for date_bus_out
- date_bus_in  input  8  external read data
- r  output  1  external read strobe
- w  output  1  external write strobe

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset values:
  - state = IDLE
  - adress_bus = 0, date_bus_out = 0
  - date_bus_oe = 0, r = 0, w = 0
  - ack0 = ack1 = 0, rdata = 0, busy = 0
  - grant = 1, so port 0 wins the first round-robin tie
  - wait counter = 0
- Reset mid-transaction aborts the access in the same edge: no ack is issued and strobes drop immediately.
- IDLE, on a clock edge:
  - Neither req: stay in IDLE.
  - One req: that port wins.
  - Both req, FIXED_PRIO = 1: port 0 wins.
  - Both req, FIXED_PRIO = 0: the port not equal to grant wins.
  - On a win: latch the winner's addr/we/wdata into adress_bus/date_bus_out.
  - Set grant = winner, set r = ~we, w = we, date_bus_oe = we.
  - Load counter = WAIT_CYCLES and go to ACCESS.
- ACCESS:
  - Bus outputs are held stable.
  - Counter decrements each cycle; state lasts WAIT_CYCLES+1 cycles.
  - On the edge leaving ACCESS (counter = 0):
    - rdata <= date_bus_in for reads; rdata is unchanged for writes.
    - r, w and date_bus_oe <= 0.
    - ack[grant] <= 1.
    - Go to DONE.
- DONE (exactly one cycle, ack high):
  - If lock[grant] and req[grant] are both high, go directly to ACCESS for the same port with new addr/we/wdata. No re-arbitration.
  - Otherwise go to IDLE.
- Latency: request sampled at edge E → ack high during cycle E+WAIT_CYCLES+2 (WAIT=1: third cycle after sampling).
- Back-to-back throughput:
  - Locked: one access per WAIT_CYCLES+2 cycles.
  - Unlocked: add one IDLE turnaround cycle.
- req deasserted during ACCESS: the access still completes and ack still pulses. Requesters must not do this.
- lock is ignored in IDLE. Lock on the non-granted port has no effect.
- Requests arriving during ACCESS/DONE wait; they are evaluated in IDLE only.
- ack0 and ack1 are never high together. At most one of r/w is high.
- date_bus_oe is high only while w is high.

Test Plan:
- WAIT_CYCLES=1, port 0 read of 0x2000 with date_bus_in=0xA5:
  - Response: r high for 2 cycles, adress_bus=0x2000, ack0 on the 3rd cycle after sampling, rdata=0xA5, w=0, oe=0.
- Port 1 write of 0x3C to 0x1F00:
  - Response: w=1, date_bus_oe=1, date_bus_out=0x3C for 2 cycles, then ack1; rdata unchanged.
- Round-robin, FIXED_PRIO=0, req0 and req1 held continuously:
  - Response: grant alternates 0,1,0,1 after reset, one ack per 4 cycles.
- FIXED_PRIO=1, same stimulus:
  - Response: only ack0 pulses; port 1 is starved while req0 is held.
- Lock: port 0 with lock0=1 reads 0x2000 then 0x2001, with req1 pending:
  - Response: DONE goes straight to ACCESS, second ack0 arrives 3 cycles after the first, then port 1 is granted.
- Reset asserted in the 1st ACCESS cycle:
  - Response: next cycle has r=w=oe=0, state IDLE, no ack; the next tie goes to port 0.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
//============================================================================
// Module      : bus_arbiter
// Description : Two-port arbiter for a single external memory bus.
//               Port 0 (CPU core) and port 1 (DMA/video fetch) compete for
//               the bus. The winner's access runs through three states:
//               IDLE (arbitration), ACCESS (WAIT_CYCLES+1 cycles with the
//               strobes driven) and DONE (one cycle with the ack pulse).
//               A locked requester can chain accesses directly from DONE
//               back into ACCESS without going through re-arbitration.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req/lock/addr/we/wdata{0,1} - requester inputs
//               ack{0,1}              - one-cycle completion pulse per port
//               rdata                 - read data, valid while an ack is high
//               grant                 - index of the current/last owner
//               busy                  - high in ACCESS and DONE
//               adress_bus, date_bus_out, date_bus_oe, date_bus_in, r, w
//                                     - external memory bus
//
// Parameters  : WAIT_CYCLES (0..15) extra cycles r/w is held
//               FIXED_PRIO  0 = round-robin, 1 = port 0 wins every tie
//
// Revision    : 1.0 - initial release
//============================================================================
module bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        lock0,
    input  logic [15:0] addr0,
    input  logic        we0,
    input  logic [7:0]  wdata0,
    output logic        ack0,

    input  logic        req1,
    input  logic        lock1,
    input  logic [15:0] addr1,
    input  logic        we1,
    input  logic [7:0]  wdata1,
    output logic        ack1,

    output logic [7:0]  rdata,
    output logic        grant,
    output logic        busy,

    output logic [15:0] adress_bus,
    output logic [7:0]  date_bus_out,
    output logic        date_bus_oe,
    input  logic [7:0]  date_bus_in,
    output logic        r,
    output logic        w
);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACCESS = 2'd1;
    localparam logic [1:0] C_ST_DONE   = 2'd2;

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

    //------------------------------------------------------------------------
    // Registers and their next-state values
    //------------------------------------------------------------------------
    logic [1:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [15:0] addr_q,   addr_d;
    logic [7:0]  wdat_q,   wdat_d;
    logic        oe_q,     oe_d;
    logic        rd_q,     rd_d;
    logic        wr_q,     wr_d;
    logic        ack0_q,   ack0_d;
    logic        ack1_q,   ack1_d;
    logic [7:0]  rdata_q,  rdata_d;
    logic        grant_q,  grant_d;

    //------------------------------------------------------------------------
    // Arbitration and start-of-access selection
    //------------------------------------------------------------------------
    logic        w_arb_port;     // winner if arbitration happens this cycle
    logic        w_start_port;   // port whose request fields get latched
    logic [15:0] w_sel_addr;
    logic        w_sel_we;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_req;
    logic        w_sel_lock;

    always_comb begin
        w_arb_port = 1'b0;
        if (req0 && req1) begin
            // Round-robin hands the tie to whichever port did not own the
            // bus last; grant resets to 1 so port 0 takes the first tie.
            w_arb_port = FIXED_PRIO ? 1'b0 : ~grant_q;
        end else if (req1) begin
            w_arb_port = 1'b1;
        end else begin
            w_arb_port = 1'b0;
        end
    end

    // In DONE a chained access can only continue for the current owner,
    // so the request mux follows grant there and the arbiter elsewhere.
    assign w_start_port = (state_q == C_ST_DONE) ? grant_q : w_arb_port;

    assign w_sel_addr  = w_start_port ? addr1  : addr0;
    assign w_sel_we    = w_start_port ? we1    : we0;
    assign w_sel_wdata = w_start_port ? wdata1 : wdata0;
    assign w_sel_req   = grant_q ? req1  : req0;
    assign w_sel_lock  = grant_q ? lock1 : lock0;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            wdat_q  <= 8'd0;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= 8'd0;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        oe_d    = oe_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack0_d  = 1'b0;      // ack is a single-cycle pulse
        ack1_d  = 1'b0;
        rdata_d = rdata_q;
        grant_d = grant_q;

        case (state_q)
            C_ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = C_ST_ACCESS;
                    cnt_d   = C_WAIT_LOAD;
                    grant_d = w_start_port;
                    addr_d  = w_sel_addr;
                    wdat_d  = w_sel_wdata;
                    rd_d    = ~w_sel_we;
                    wr_d    = w_sel_we;
                    oe_d    = w_sel_we;
                end
            end

            C_ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Capture read data on the closing edge; writes leave
                    // the last read value in place.
                    if (rd_q) begin
                        rdata_d = date_bus_in;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    oe_d    = 1'b0;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = C_ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            C_ST_DONE: begin
                if (w_sel_lock && w_sel_req) begin
                    state_d = C_ST_ACCESS;
                    cnt_d   = C_WAIT_LOAD;
                    addr_d  = w_sel_addr;
                    wdat_d  = w_sel_wdata;
                    rd_d    = ~w_sel_we;
                    wr_d    = w_sel_we;
                    oe_d    = w_sel_we;
                end else begin
                    state_d = C_ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: park safely with the bus released.
                state_d = C_ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                oe_d    = 1'b0;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Output logic
    //------------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == C_ST_ACCESS) || (state_q == C_ST_DONE);
        ack0         = ack0_q;
        ack1         = ack1_q;
        rdata        = rdata_q;
        grant        = grant_q;
        adress_bus   = addr_q;
        date_bus_out = wdat_q;
        date_bus_oe  = oe_q;
        r            = rd_q;
        w            = wr_q;
    end

`ifndef SYNTHESIS
    // Structural invariants of the bus interface.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ack0_q && ack1_q));
            assert (!(rd_q && wr_q));
            assert (!oe_q || wr_q);
        end
    end
`endif

endmodule
`default_nettype wire
